// File: rtl/jpc_operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 through one register-file port and hands them to execute.
// Optional writeback forwarding is enabled by defining JPC_OPFETCH_FWD_EN.
`ifndef JPC_REGDATA_WIDTH
`define JPC_REGDATA_WIDTH 32
`endif

module jpc_operand_fetch #(
  parameter int XLEN  = `JPC_REGDATA_WIDTH,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_I,
  output logic             in_ready_O,
  input  logic [4:0]       in_rs1_I,
  input  logic [4:0]       in_rs2_I,
  input  logic             in_use_rs1_I,
  input  logic             in_use_rs2_I,
  input  logic [TAG_W-1:0] in_tag_I,
  output logic             rf_idx_op_O,
  output logic [4:0]       rf_idx_O,
  output logic             rf_idx_valid_O,
  input  logic             rf_idx_ready_I,
  output logic             rf_rdata_ready_O,
  input  logic [XLEN-1:0]  rf_rdata_I,
  input  logic             rf_rdata_valid_I,
  output logic             out_valid_O,
  input  logic             out_ready_I,
  output logic [XLEN-1:0]  out_rs1_val_O,
  output logic [XLEN-1:0]  out_rs2_val_O,
  output logic [TAG_W-1:0] out_tag_O,
  input  logic             wb_valid_I,
  input  logic [4:0]       wb_idx_I,
  input  logic [XLEN-1:0]  wb_data_I
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       rs1_q, rs2_q;
  logic             use1_q, use2_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  rs1_val_q, rs2_val_q;
  logic [XLEN-1:0]  rs1_val_nxt, rs2_val_nxt;
  logic             load;
  logic             need2;
  logic             fwd1, fwd2;

  assign need2 = use2_q && (rs2_q != 5'd0);

`ifdef JPC_OPFETCH_FWD_EN
  assign fwd1 = wb_valid_I && (wb_idx_I == rs1_q) && (rs1_q != 5'd0) && use1_q;
  assign fwd2 = wb_valid_I && (wb_idx_I == rs2_q) && (rs2_q != 5'd0) && use2_q;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_I, wb_idx_I, wb_data_I};
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use1_q    <= 1'b0;
      use2_q    <= 1'b0;
      tag_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
    end else begin
      state     <= state_nxt;
      rs1_val_q <= rs1_val_nxt;
      rs2_val_q <= rs2_val_nxt;
      if (load) begin
        rs1_q  <= in_rs1_I;
        rs2_q  <= in_rs2_I;
        use1_q <= in_use_rs1_I;
        use2_q <= in_use_rs2_I;
        tag_q  <= in_tag_I;
      end
    end
  end

  // A forwarding match on an already-held operand always overwrites it, so the newest write wins.
  always_comb begin
    state_nxt        = state;
    in_ready_O       = 1'b0;
    rf_idx_valid_O   = 1'b0;
    rf_idx_O         = 5'd0;
    rf_rdata_ready_O = 1'b0;
    out_valid_O      = 1'b0;
    load             = 1'b0;
    rs1_val_nxt      = rs1_val_q;
    rs2_val_nxt      = rs2_val_q;
    case (state)
      IDLE: begin
        in_ready_O = 1'b1;
        if (in_valid_I) begin
          load        = 1'b1;
          rs1_val_nxt = '0;
          rs2_val_nxt = '0;
          if (in_use_rs1_I && (in_rs1_I != 5'd0))      state_nxt = REQ1;
          else if (in_use_rs2_I && (in_rs2_I != 5'd0)) state_nxt = REQ2;
          else                                         state_nxt = OUT;
        end
      end
      REQ1: begin
        if (fwd1) begin
          rs1_val_nxt = wb_data_I;
          state_nxt   = need2 ? REQ2 : OUT;
        end else begin
          rf_idx_valid_O = 1'b1;
          rf_idx_O       = rs1_q;
          if (rf_idx_ready_I) state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        rf_rdata_ready_O = 1'b1;
        if (rf_rdata_valid_I) begin
          rs1_val_nxt = rf_rdata_I;
          state_nxt   = need2 ? REQ2 : OUT;
        end
        if (fwd1) rs1_val_nxt = wb_data_I;
      end
      REQ2: begin
        if (fwd1) rs1_val_nxt = wb_data_I;
        if (fwd2) begin
          rs2_val_nxt = wb_data_I;
          state_nxt   = OUT;
        end else begin
          rf_idx_valid_O = 1'b1;
          rf_idx_O       = rs2_q;
          if (rf_idx_ready_I) state_nxt = WAIT2;
        end
      end
      WAIT2: begin
        rf_rdata_ready_O = 1'b1;
        if (rf_rdata_valid_I) begin
          rs2_val_nxt = rf_rdata_I;
          state_nxt   = OUT;
        end
        if (fwd2) rs2_val_nxt = wb_data_I;
        if (fwd1) rs1_val_nxt = wb_data_I;
      end
      OUT: begin
        out_valid_O = 1'b1;
        if (fwd1) rs1_val_nxt = wb_data_I;
        if (fwd2) rs2_val_nxt = wb_data_I;
        if (out_ready_I) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rf_idx_op_O   = 1'b0;
  assign out_rs1_val_O = rs1_val_q;
  assign out_rs2_val_O = rs2_val_q;
  assign out_tag_O     = tag_q;

endmodule
